dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter_starve_counter.sv | 24 ++
 rtl/dmem_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, grant-select encoding and request payload for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W = 7;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned STARVE_W    = 4;

    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_sel_e;

    // One requester's memory access, as muxed onto the memory side.
    typedef struct packed {
        logic                   write;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader port, the data memory and the arbiter.
//   slave  : arbiter view (requests and memory read data in; stall/grant/read data/strobes out)
//   master : environment view (requesters and memory)
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic                   PipeReq;
    logic                   PipeWrite;
    logic [DMEM_ADDR_W-1:0] PipeAddr;
    logic [DMEM_DATA_W-1:0] PipeWData;
    logic                   PipeStall;
    logic [DMEM_DATA_W-1:0] PipeRData;

    logic                   DmaReq;
    logic                   DmaWrite;
    logic [DMEM_ADDR_W-1:0] DmaAddr;
    logic [DMEM_DATA_W-1:0] DmaWData;
    logic                   DmaGnt;
    logic [DMEM_DATA_W-1:0] DmaRData;
    logic                   DmaRValid;

    logic [DMEM_ADDR_W-1:0] MemAddress;
    logic [DMEM_DATA_W-1:0] MemWriteData;
    logic                   MemRead;
    logic                   MemWrite;
    logic [DMEM_DATA_W-1:0] MemReadData;

    modport slave (
        input  PipeReq, PipeWrite, PipeAddr, PipeWData,
        input  DmaReq, DmaWrite, DmaAddr, DmaWData,
        input  MemReadData,
        output PipeStall, PipeRData,
        output DmaGnt, DmaRData, DmaRValid,
        output MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport master (
        output PipeReq, PipeWrite, PipeAddr, PipeWData,
        output DmaReq, DmaWrite, DmaAddr, DmaWData,
        output MemReadData,
        input  PipeStall, PipeRData,
        input  DmaGnt, DmaRData, DmaRValid,
        input  MemAddress, MemWriteData, MemRead, MemWrite
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating counter of consecutive denied DMA cycles.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one more denied cycle (holds at max)
//   clr      : return to zero (wins over inc)
//   cnt      : current count
module dmem_arbiter_starve_counter
    import dmem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != STARVE_MAX)) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: MEM stage has priority, DMA is forced through after
// STARVE_LIMIT consecutive denied cycles. Grant and memory strobes are combinational;
// read data returns one cycle after a granted read.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : requester ports, memory port, stall/grant and registered read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    gnt_sel_e            gnt_sel;
    mem_req_t            pipe_req;
    mem_req_t            dma_req;
    mem_req_t            sel_req;
    logic                dma_gnt;
    logic                any_gnt;
    logic                dma_denied;

    always_comb begin
        pipe_req = '{write: bus.PipeWrite, addr: bus.PipeAddr, wdata: bus.PipeWData};
        dma_req  = '{write: bus.DmaWrite,  addr: bus.DmaAddr,  wdata: bus.DmaWData};
    end

    // Pipe wins unless DMA has been starved long enough; DMA takes any cycle the pipe leaves.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (bus.PipeReq && (starve_cnt < LIMIT)) begin
            gnt_sel = GNT_PIPE;
        end else if (bus.DmaReq) begin
            gnt_sel = GNT_DMA;
        end
    end

    // Memory-side mux; idle cycles drive zeros.
    always_comb begin
        sel_req = '0;
        case (gnt_sel)
            GNT_PIPE: sel_req = pipe_req;
            GNT_DMA:  sel_req = dma_req;
            default:  sel_req = '0;
        endcase
    end

    assign dma_gnt    = (gnt_sel == GNT_DMA);
    assign any_gnt    = (gnt_sel != GNT_NONE);
    assign dma_denied = bus.DmaReq && !dma_gnt;

    assign bus.MemAddress   = sel_req.addr;
    assign bus.MemWriteData = sel_req.wdata;
    assign bus.MemRead      = any_gnt && !sel_req.write;
    assign bus.MemWrite     = any_gnt && sel_req.write;
    assign bus.DmaGnt       = dma_gnt;
    assign bus.PipeStall    = bus.PipeReq && dma_gnt;

    dmem_arbiter_starve_counter u_starve_counter (
        .clk (Clk),
        .rst (Reset),
        .inc (dma_denied),
        .clr (!dma_denied),
        .cnt (starve_cnt)
    );

    // Capture read data for whichever port read this cycle; other port holds.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.PipeRData <= '0;
            bus.DmaRData  <= '0;
            bus.DmaRValid <= 1'b0;
        end else begin
            bus.DmaRValid <= dma_gnt && !bus.DmaWrite;
            if ((gnt_sel == GNT_PIPE) && !bus.PipeWrite) begin
                bus.PipeRData <= bus.MemReadData;
            end
            if (dma_gnt && !bus.DmaWrite) begin
                bus.DmaRData <= bus.MemReadData;
            end
        end
    end

endmodule
